// File: rtl/demux_burst_scheduler.sv
// demux_burst_scheduler
//   Round-robin scheduler that shares one input stream among four output
//   channels. Each enabled channel gets a fixed-length burst of BURST_LEN
//   beats, then the scheduler rotates to the next enabled channel. The
//   output is a one-entry registered buffer with per-channel valid/ready
//   backpressure.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   in_data     input beat
//   in_valid    input beat present
//   in_ready    scheduler accepts the beat this cycle
//   chan_en     per-channel enable, sampled every cycle
//   out_data    shared registered output data bus
//   out_valid   one-hot, bit i = beat valid for channel i
//   out_ready   per-channel consumer ready
//   cur_sel     channel currently being scheduled
//   burst_done  one-cycle pulse after the last beat of a burst is accepted
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no channel enabled; nothing accepted, buffer may still drain
// RUN   | bursting to cur_sel; accepts when the channel is enabled and the
//       | output buffer is empty or is being drained this cycle
module demux_burst_scheduler #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        chan_en,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        cur_sel,
  output logic              burst_done
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             buf_free;
  logic             accept;

  // First enabled channel scanning start, start+1, start+2, start+3 (mod 4).
  // Iterating from the far end down lets the nearest hit win; fallback is
  // returned when no channel is enabled.
  function automatic logic [1:0] scan_from(input logic [1:0] start,
                                           input logic [3:0] en,
                                           input logic [1:0] fallback);
    logic [1:0] r;
    logic [1:0] idx;
    r = fallback;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (en[idx]) r = idx;
    end
    return r;
  endfunction

  // The buffer can take a new beat if it is empty or its current beat is
  // handed off on this same edge. Ready bits of other channels never match
  // the one-hot valid, so they are ignored automatically.
  assign buf_free = (out_valid == 4'b0000) || ((out_valid & out_ready) != 4'b0000);
  assign in_ready = (state == RUN) && chan_en[cur_sel] && buf_free;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_sel    <= 2'd0;
      cnt        <= '0;
      out_valid  <= 4'b0000;
      out_data   <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;

      // Output buffer: refill wins over drain; data is held otherwise.
      if (accept) begin
        out_data  <= in_data;
        out_valid <= 4'b0001 << cur_sel;
      end else if ((out_valid & out_ready) != 4'b0000) begin
        out_valid <= 4'b0000;
      end

      case (state)
        IDLE: begin
          if (chan_en != 4'b0000) begin
            state   <= RUN;
            cur_sel <= scan_from(cur_sel, chan_en, cur_sel);
            cnt     <= '0;
          end
        end

        RUN: begin
          if (!chan_en[cur_sel]) begin
            // Channel dropped mid-burst: abandon the burst, move on. A beat
            // already in the buffer keeps its original one-hot valid.
            cnt     <= '0;
            cur_sel <= scan_from(cur_sel + 2'd1, chan_en, cur_sel);
            if (chan_en == 4'b0000) state <= IDLE;
          end else if (accept) begin
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              burst_done <= 1'b1;
              cur_sel    <= scan_from(cur_sel + 2'd1, chan_en, cur_sel);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_burst_scheduler.sv
module tb_demux_burst_scheduler;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] chan_en;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] cur_sel;
  logic       burst_done;

  demux_burst_scheduler #(.DATA_W(8), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .chan_en    (chan_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cur_sel    (cur_sel),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Channel numbers are plain ints; the buffer is (valid, channel, data).
  int         m_run = 0, m_sel = 0, m_cnt = 0, m_bch = 0;
  bit         m_bv = 0, m_done = 0, m_acc = 0, started = 0;
  logic [7:0] m_bdata = 8'h00;

  function automatic int nxt(input int x, input logic [3:0] en);
    for (int k = 1; k <= 4; k++) if (en[(x + k) % 4]) return (x + k) % 4;
    return x;
  endfunction

  function automatic int first_from(input int x, input logic [3:0] en);
    for (int k = 0; k <= 3; k++) if (en[(x + k) % 4]) return (x + k) % 4;
    return x;
  endfunction

  function automatic bit model_ready();
    return (m_run != 0) && chan_en[m_sel] && (!m_bv || out_ready[m_bch]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_sel = 0; m_cnt = 0; m_bch = 0;
      m_bv = 0; m_done = 0; m_acc = 0; m_bdata = 8'h00;
      started = 1;
    end else begin
      m_acc  = in_valid && model_ready();
      m_done = 0;
      if (m_acc) begin
        m_bv = 1; m_bch = m_sel; m_bdata = in_data;
      end else if (m_bv && out_ready[m_bch]) begin
        m_bv = 0;
      end
      if (m_run == 0) begin
        if (chan_en != 4'b0000) begin
          m_run = 1; m_sel = first_from(m_sel, chan_en); m_cnt = 0;
        end
      end else if (!chan_en[m_sel]) begin
        m_cnt = 0;
        m_sel = nxt(m_sel, chan_en);
        if (chan_en == 4'b0000) m_run = 0;
      end else if (m_acc) begin
        m_cnt++;
        if (m_cnt == BL) begin
          m_cnt = 0; m_done = 1; m_sel = nxt(m_sel, chan_en);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",   32'(in_ready),   32'(model_ready()));
      chk("out_valid",  32'(out_valid),  m_bv ? (32'd1 << m_bch) : 32'd0);
      chk("out_data",   32'(out_data),   32'(m_bdata));
      chk("cur_sel",    32'(cur_sel),    32'(m_sel));
      chk("burst_done", 32'(burst_done), 32'(m_done));
    end
  end

  // Delivery log per channel and burst_done pulse count.
  logic [7:0] dlog [4][$];
  int         n_done = 0;

  always @(negedge clk) begin
    if (started && !rst) begin
      for (int i = 0; i < 4; i++)
        if (out_valid[i] && out_ready[i]) dlog[i].push_back(out_data);
      if (burst_done) n_done++;
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) dlog[i].delete();
    n_done = 0;
  endtask

  task automatic chk_seq(input int ch, input int idx0, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      if (idx0 + k < dlog[ch].size())
        chk($sformatf("log_ch%0d_%0d", ch, idx0 + k), 32'(dlog[ch][idx0 + k]), 32'(base + k));
      else
        chk($sformatf("log_ch%0d_missing_%0d", ch, idx0 + k), 32'(dlog[ch].size()), 32'(idx0 + k + 1));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_n(input int n, input logic [7:0] d0, output int cyc);
    int sent;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 40 * n) begin
      in_valid = 1'b1;
      in_data  = 8'(d0 + sent);
      @(posedge clk);
      #1;
      cyc++;
      if (m_acc) sent++;
    end
    in_valid = 1'b0;
    if (sent < n) chk("send_timeout", 32'(sent), 32'(n));
  endtask

  int cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    chan_en = 4'hF; out_ready = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),   32'd0);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_out_data",  32'(out_data),   32'd0);
    chk("rst_cur_sel",   32'(cur_sel),    32'd0);
    chk("rst_burst_done",32'(burst_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: all channels, 16 beats, continuous ready
    clear_logs();
    send_n(16, 8'h00, cyc);
    chk("t1_cycles", 32'(cyc), 32'd17);
    idle(2);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t1_size_ch%0d", c), 32'(dlog[c].size()), 32'd4);
      chk_seq(c, 0, c * 4, 4);
    end
    chk("t1_done", 32'(n_done), 32'd4);
    chk("t1_sel", 32'(cur_sel), 32'd0);

    // 2: channels 0 and 2 only
    clear_logs();
    chan_en = 4'b0101;
    send_n(12, 8'h20, cyc);
    idle(2);
    chk("t2_size_ch0", 32'(dlog[0].size()), 32'd8);
    chk("t2_size_ch1", 32'(dlog[1].size()), 32'd0);
    chk("t2_size_ch2", 32'(dlog[2].size()), 32'd4);
    chk("t2_size_ch3", 32'(dlog[3].size()), 32'd0);
    chk_seq(0, 0, 'h20, 4);
    chk_seq(2, 0, 'h24, 4);
    chk_seq(0, 4, 'h28, 4);
    chk("t2_done", 32'(n_done), 32'd3);
    chk("t2_sel", 32'(cur_sel), 32'd2);

    // 3: stall channel 0 for 5 cycles after its first beat
    chan_en = 4'b0001;
    idle(1);
    clear_logs();
    send_n(1, 8'h30, cyc);
    out_ready = 4'b1110;
    in_valid = 1'b1; in_data = 8'h31;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid), 32'h1);
      chk("t3_hold_data",  32'(out_data),  32'h30);
      chk("t3_hold_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    send_n(3, 8'h31, cyc);
    idle(2);
    chk("t3_size_ch0", 32'(dlog[0].size()), 32'd4);
    chk_seq(0, 0, 'h30, 4);
    chk("t3_done", 32'(n_done), 32'd1);
    chk("t3_sel", 32'(cur_sel), 32'd0);

    // 4: drop channel 1 two beats into its burst, pending beat held
    clear_logs();
    chan_en = 4'hF;
    send_n(4, 8'h40, cyc);
    send_n(2, 8'h44, cyc);
    chan_en = 4'b1101; out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 8'h46;
    repeat (2) begin
      @(negedge clk);
      chk("t4_blocked", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    send_n(4, 8'h46, cyc);
    idle(2);
    chk("t4_size_ch1", 32'(dlog[1].size()), 32'd2);
    chk_seq(0, 0, 'h40, 4);
    chk_seq(1, 0, 'h44, 2);
    chk("t4_size_ch2", 32'(dlog[2].size()), 32'd4);
    chk_seq(2, 0, 'h46, 4);
    chk("t4_done", 32'(n_done), 32'd2);
    chk("t4_sel", 32'(cur_sel), 32'd3);

    // 5: all disabled in RUN -> IDLE, then re-enable channel 3 only
    clear_logs();
    chan_en = 4'b0000;
    in_valid = 1'b1; in_data = 8'h50;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_idle_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chan_en = 4'b1000;
    send_n(2, 8'h50, cyc);
    chk("t5_cycles", 32'(cyc), 32'd3);
    idle(2);
    chk("t5_size_ch3", 32'(dlog[3].size()), 32'd2);
    chk_seq(3, 0, 'h50, 2);
    chk("t5_sel", 32'(cur_sel), 32'd3);

    // 6: reset with a beat pending on channel 1
    chan_en = 4'b0010;
    idle(1);
    clear_logs();
    out_ready = 4'b0000;
    send_n(1, 8'h61, cyc);
    @(negedge clk);
    chk("t6_pending", 32'(out_valid), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_sel",   32'(cur_sel),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chan_en = 4'hF; out_ready = 4'hF;
    clear_logs();
    send_n(4, 8'h70, cyc);
    chk("t6_cycles", 32'(cyc), 32'd5);
    idle(2);
    chk("t6_size_ch0", 32'(dlog[0].size()), 32'd4);
    chk_seq(0, 0, 'h70, 4);
    chk("t6_size_ch1", 32'(dlog[1].size()), 32'd0);
    chk("t6_done", 32'(n_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
